// File: rtl/kinase_valve_sequencer_pkg.sv
// rtl/kinase_valve_sequencer_pkg.sv - valve widths, step entry layout, FSM states and pump patterns
package kinase_ctrl_pkg;

  localparam int N_CTRL_A   = 13;
  localparam int N_CTRL_S   = 4;
  localparam int N_PUMP_A   = 3;
  localparam int N_PUMP_B   = 2;
  localparam int N_PH_A     = 6;
  localparam int N_PH_B     = 2;
  localparam int STEP_HDR_W = 2 + N_CTRL_S + N_CTRL_A;

  // Upper part of a prog_data word; the duration field sits directly below it.
  typedef struct packed {
    logic                pump_b_en;
    logic                pump_a_en;
    logic [N_CTRL_S-1:0] ctrl_s;
    logic [N_CTRL_A-1:0] ctrl_a;
  } step_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Element 0 is phase 0; 1 = valve closed.
  localparam logic [N_PH_A-1:0][N_PUMP_A-1:0] PUMP_A_PAT =
    {3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011};
  localparam logic [N_PH_B-1:0][N_PUMP_B-1:0] PUMP_B_PAT = {2'b01, 2'b10};

endpackage

// File: rtl/kinase_valve_sequencer_if.sv
// rtl/kinase_valve_sequencer_if.sv - host program/control bus and valve outputs of the sequencer
interface kinase_valve_sequencer_if
  import kinase_ctrl_pkg::*;
#(
  parameter int N_STEPS = 16,
  parameter int DUR_W   = 16,
  parameter int DIV_W   = 12
);
  localparam int AW = $clog2(N_STEPS);

  logic                        prog_we;
  logic [AW-1:0]               prog_addr;
  logic [STEP_HDR_W+DUR_W-1:0] prog_data;
  logic [AW-1:0]               last_step;
  logic [DIV_W-1:0]            pump_div;
  logic                        start;
  logic                        abort;
  logic                        flush_req;
  logic                        busy;
  logic                        done;
  logic                        flush_active;
  logic [AW-1:0]               step_idx;
  logic [N_CTRL_A-1:0]         valve_ctrl_a;
  logic [N_CTRL_S-1:0]         valve_ctrl_s;
  logic [N_PUMP_A-1:0]         valve_pump_a;
  logic [N_PUMP_B-1:0]         valve_pump_b;

  modport master (
    output prog_we, prog_addr, prog_data, last_step, pump_div, start, abort, flush_req,
    input  busy, done, flush_active, step_idx,
    input  valve_ctrl_a, valve_ctrl_s, valve_pump_a, valve_pump_b
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, last_step, pump_div, start, abort, flush_req,
    output busy, done, flush_active, step_idx,
    output valve_ctrl_a, valve_ctrl_s, valve_pump_a, valve_pump_b
  );

endinterface

// File: rtl/kinase_valve_sequencer_pump_gen.sv
// rtl/kinase_valve_sequencer_pump_gen.sv - phase stepper for one pump; the output register shows
// the phase of the previous cycle, so every pattern is held a full divider period
module kinase_pump_gen
  import kinase_ctrl_pkg::*;
#(
  parameter int N_VALVE = 3,
  parameter int N_PHASE = 6,
  parameter logic [N_PHASE-1:0][N_VALVE-1:0] PAT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_act,
  input  logic               i_seal,
  input  logic               i_en,
  input  logic               i_tick,
  output logic [N_VALVE-1:0] o_valve
);

  localparam int PH_W = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;

  logic [PH_W-1:0] r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      o_valve <= '0;
    end else if (i_clr) begin
      r_phase <= '0;
      o_valve <= '0;
    end else if (i_seal) begin
      o_valve <= '1;
    end else if (i_act) begin
      o_valve <= i_en ? PAT[r_phase] : '1;
      if (i_tick && i_en)
        r_phase <= (r_phase == PH_W'(N_PHASE - 1)) ? '0 : r_phase + 1'b1;
    end else begin
      o_valve <= '0;
    end
  end

endmodule

// File: rtl/kinase_valve_sequencer.sv
// rtl/kinase_valve_sequencer.sv - step table, sequencing FSM, flush timer and pump generators
module kinase_valve_sequencer
  import kinase_ctrl_pkg::*;
#(
  parameter int N_STEPS      = 16,
  parameter int DUR_W        = 16,
  parameter int DIV_W        = 12,
  parameter int FLUSH_CYCLES = 1024
) (
  input logic                    clk,
  input logic                    rst_n,
  kinase_valve_sequencer_if.slave bus
);

  localparam int AW    = $clog2(N_STEPS);
  localparam int FC_W  = $clog2(FLUSH_CYCLES) + 1;
  localparam int ENT_W = STEP_HDR_W + DUR_W;

  logic [ENT_W-1:0]    r_table [N_STEPS];
  logic [ENT_W-1:0]    r_rd;
  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_idx, w_idx_nxt, r_last;
  logic [DIV_W-1:0]    r_div, r_pump_div;
  logic [DUR_W-1:0]    r_dur;
  logic [FC_W-1:0]     r_fcnt;
  logic [N_CTRL_A-1:0] r_ctrl_a;
  logic [N_CTRL_S-1:0] r_ctrl_s;
  logic                r_a_en, r_b_en, r_done, r_busy, r_flush;
  step_t               w_rd_hdr;
  logic [DUR_W-1:0]    w_rd_dur;
  logic                w_start, w_abort, w_expire, w_tick, w_act, w_seal, w_en_a, w_en_b;
  logic [N_PUMP_A-1:0] w_pump_a;
  logic [N_PUMP_B-1:0] w_pump_b;

  assign w_rd_hdr = step_t'(r_rd[ENT_W-1:DUR_W]);
  assign w_rd_dur = r_rd[DUR_W-1:0];
  assign w_start  = (r_state == ST_IDLE) && bus.start && !bus.flush_req;
  assign w_abort  = bus.abort && (r_state inside {ST_LOAD, ST_RUN, ST_FLUSH});
  assign w_expire = (r_state == ST_RUN) && (r_dur == DUR_W'(1));
  assign w_tick   = (r_div == r_pump_div);
  assign w_act    = (r_state inside {ST_LOAD, ST_RUN}) && (w_state_nxt inside {ST_LOAD, ST_RUN});
  assign w_seal   = (w_state_nxt == ST_FLUSH);
  // While loading, the entry about to be applied already decides whether its pumps move.
  assign w_en_a   = (r_state == ST_LOAD) ? w_rd_hdr.pump_a_en : r_a_en;
  assign w_en_b   = (r_state == ST_LOAD) ? w_rd_hdr.pump_b_en : r_b_en;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.flush_req) w_state_nxt = ST_FLUSH;
                  else if (bus.start) w_state_nxt = ST_LOAD;
        ST_LOAD:  w_state_nxt = ST_RUN;
        ST_RUN:   if (w_expire) begin
                    if (r_idx >= r_last) begin
                      w_state_nxt = ST_DONE;
                      w_idx_nxt   = '0;
                    end else begin
                      w_state_nxt = ST_LOAD;
                      w_idx_nxt   = r_idx + 1'b1;
                    end
                  end
        ST_FLUSH: if (r_fcnt == '0) w_state_nxt = ST_IDLE;
        ST_DONE:  w_state_nxt = bus.flush_req ? ST_FLUSH : ST_IDLE;
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Read address is the next step index, so the entry is ready during the LOAD cycle.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !r_busy) r_table[bus.prog_addr] <= bus.prog_data;
    r_rd <= r_table[w_idx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_last     <= '0;
      r_pump_div <= '0;
      r_div      <= '0;
      r_dur      <= '0;
      r_fcnt     <= '0;
      r_ctrl_a   <= '0;
      r_ctrl_s   <= '0;
      r_a_en     <= 1'b0;
      r_b_en     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt inside {ST_LOAD, ST_RUN, ST_FLUSH});
      r_flush <= (w_state_nxt == ST_FLUSH);
      if (w_start) begin
        r_last     <= bus.last_step;
        r_pump_div <= bus.pump_div;
      end
      if (w_start)    r_div <= '0;
      else if (w_act) r_div <= w_tick ? '0 : r_div + 1'b1;
      if (r_state != ST_FLUSH && w_state_nxt == ST_FLUSH) r_fcnt <= FC_W'(FLUSH_CYCLES - 1);
      else if (r_state == ST_FLUSH && r_fcnt != '0)      r_fcnt <= r_fcnt - 1'b1;
      if (r_state == ST_LOAD && w_state_nxt == ST_RUN) begin
        r_ctrl_a <= w_rd_hdr.ctrl_a;
        r_ctrl_s <= w_rd_hdr.ctrl_s;
        r_a_en   <= w_rd_hdr.pump_a_en;
        r_b_en   <= w_rd_hdr.pump_b_en;
        r_dur    <= (w_rd_dur == '0) ? DUR_W'(1) : w_rd_dur;
      end else if (w_state_nxt == ST_RUN) begin
        r_dur <= r_dur - 1'b1;
      end else if (w_state_nxt == ST_LOAD) begin
        r_ctrl_a <= r_ctrl_a;
        r_ctrl_s <= r_ctrl_s;
      end else if (w_state_nxt == ST_FLUSH) begin
        r_ctrl_a <= '1;
        r_ctrl_s <= '1;
      end else begin
        r_ctrl_a <= '0;
        r_ctrl_s <= '0;
      end
    end
  end

  kinase_pump_gen #(.N_VALVE(N_PUMP_A), .N_PHASE(N_PH_A), .PAT(PUMP_A_PAT)) u_pump_a (
    .clk(clk), .rst_n(rst_n), .i_clr(w_start), .i_act(w_act), .i_seal(w_seal),
    .i_en(w_en_a), .i_tick(w_tick), .o_valve(w_pump_a)
  );

  kinase_pump_gen #(.N_VALVE(N_PUMP_B), .N_PHASE(N_PH_B), .PAT(PUMP_B_PAT)) u_pump_b (
    .clk(clk), .rst_n(rst_n), .i_clr(w_start), .i_act(w_act), .i_seal(w_seal),
    .i_en(w_en_b), .i_tick(w_tick), .o_valve(w_pump_b)
  );

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.flush_active = r_flush;
  assign bus.step_idx     = r_idx;
  assign bus.valve_ctrl_a = r_ctrl_a;
  assign bus.valve_ctrl_s = r_ctrl_s;
  assign bus.valve_pump_a = w_pump_a;
  assign bus.valve_pump_b = w_pump_b;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// tb/tb_kinase_valve_sequencer.sv - vector table plus model-checked program runs for the valve sequencer
module tb_kinase_valve_sequencer;
  import kinase_ctrl_pkg::*;

  localparam int NS = 16;
  localparam int DW = 16;
  localparam int VW = 12;
  localparam int FC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kinase_valve_sequencer_if #(.N_STEPS(NS), .DUR_W(DW), .DIV_W(VW)) bus ();
  kinase_valve_sequencer #(.N_STEPS(NS), .DUR_W(DW), .DIV_W(VW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        flush;
    logic [3:0]  idx;
    logic [12:0] ca;
    logic [3:0]  cs;
    logic [2:0]  pa;
    logic [1:0]  pb;
  } out_t;

  typedef struct {
    bit          a_en;
    bit          b_en;
    logic [3:0]  cs;
    logic [12:0] ca;
    int          dur;
  } ent_t;

  typedef struct {
    bit st, fl, ab;
    bit busy, flush, ones;
  } vec_t;

  ent_t       m_tab [NS];
  out_t       exp_q [$];
  logic [2:0] pat_a [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
  logic [1:0] pat_b [2] = '{2'b10, 2'b01};
  vec_t       vt [14];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t sample();
    return {bus.busy, bus.done, bus.flush_active, bus.step_idx, bus.valve_ctrl_a,
            bus.valve_ctrl_s, bus.valve_pump_a, bus.valve_pump_b};
  endfunction

  task automatic check(input out_t e, input string nm, input int k);
    out_t g;
    g = sample();
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s[%0d]: got busy=%b done=%b fl=%b idx=%0d a=%h s=%h pa=%b pb=%b, want busy=%b done=%b fl=%b idx=%0d a=%h s=%h pa=%b pb=%b",
               nm, k, g.busy, g.done, g.flush, g.idx, g.ca, g.cs, g.pa, g.pb,
               e.busy, e.done, e.flush, e.idx, e.ca, e.cs, e.pa, e.pb);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.a_en = 1'($urandom_range(0, 1));
    e.b_en = 1'($urandom_range(0, 1));
    e.cs   = 4'($urandom);
    e.ca   = 13'($urandom);
    e.dur  = $urandom_range(0, 5);
    return e;
  endfunction

  function automatic ent_t mk_ent(bit a, bit b, logic [3:0] cs, logic [12:0] ca, int dur);
    ent_t e;
    e.a_en = a; e.b_en = b; e.cs = cs; e.ca = ca; e.dur = dur;
    return e;
  endfunction

  function automatic logic [34:0] pack(ent_t e);
    return {e.b_en, e.a_en, e.cs, e.ca, 16'(e.dur)};
  endfunction

  task automatic clear_inputs();
    bus.prog_we = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.flush_req = 1'b0;
  endtask

  task automatic prog_write(input int a, input ent_t e);
    bus.prog_we = 1'b1; bus.prog_addr = 4'(a); bus.prog_data = pack(e);
    m_tab[a] = e;
    tick();
    bus.prog_we = 1'b0;
  endtask

  // Expected per-cycle outputs from the cycle after start is sampled, through DONE and back to rest.
  task automatic build_trace(input int last, input int div, input int done_act);
    int   c_idx [$];
    int   c_ctl [$];
    int   c_en [$];
    int   pha, phb, pe, d;
    out_t e;
    c_idx.push_back(0); c_ctl.push_back(-1); c_en.push_back(0);
    for (int s = 0; s <= last; s++) begin
      d = (m_tab[s].dur == 0) ? 1 : m_tab[s].dur;
      for (int j = 0; j < d; j++) begin
        c_idx.push_back(s); c_ctl.push_back(s); c_en.push_back(s);
      end
      if (s < last) begin
        c_idx.push_back(s + 1); c_ctl.push_back(s); c_en.push_back(s + 1);
      end
    end
    exp_q.delete();
    pha = 0; phb = 0;
    for (int k = 0; k < c_idx.size(); k++) begin
      e = '0;
      e.busy = 1'b1;
      e.idx  = 4'(c_idx[k]);
      if (c_ctl[k] >= 0) begin
        e.ca = m_tab[c_ctl[k]].ca;
        e.cs = m_tab[c_ctl[k]].cs;
      end
      if (k > 0) begin
        pe   = c_en[k-1];
        e.pa = m_tab[pe].a_en ? pat_a[pha] : 3'b111;
        e.pb = m_tab[pe].b_en ? pat_b[phb] : 2'b11;
        if ((k - 1) % (div + 1) == div) begin
          if (m_tab[pe].a_en) pha = (pha + 1) % 6;
          if (m_tab[pe].b_en) phb = (phb + 1) % 2;
        end
      end
      exp_q.push_back(e);
    end
    e = '0; e.done = 1'b1;
    exp_q.push_back(e);
    if (done_act == 1) begin
      for (int k = 0; k < FC; k++) begin
        e = '1; e.done = 1'b0; e.idx = '0;
        exp_q.push_back(e);
      end
    end
    exp_q.push_back('0);
  endtask

  task automatic run_prog(input int last, input int div, input bit noise, input int abort_at,
                          input int done_act, input string nm);
    ent_t ne;
    build_trace(last, div, done_act);
    bus.last_step = 4'(last); bus.pump_div = 12'(div); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.last_step = 4'($urandom); bus.pump_div = 12'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) tick();
      check(exp_q[k], nm, k);
      clear_inputs();
      if (k == abort_at) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check('0, {nm, "_abort"}, 0);
        tick();
        check('0, {nm, "_abort"}, 1);
        return;
      end
      if (exp_q[k].done && done_act == 1) bus.flush_req = 1'b1;
      if (exp_q[k].done && done_act == 2) begin
        ne = rand_ent();
        bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = pack(ne);
        m_tab[0] = ne;
      end
      if (noise && exp_q[k].busy && !exp_q[k].flush) begin
        bus.flush_req = 1'($urandom_range(0, 1));
        bus.start     = 1'($urandom_range(0, 1));
        bus.prog_we   = 1'($urandom_range(0, 1));
        bus.prog_addr = ($urandom_range(0, 1) != 0) ? exp_q[k].idx : 4'($urandom);
        bus.prog_data = 35'({$urandom, $urandom});
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    bus.prog_addr = '0; bus.prog_data = '0; bus.last_step = '0; bus.pump_div = '0;
    tick(); tick();
    check('0, "reset", 0);
    rst_n = 1'b1;
    tick();
    check('0, "idle", 0);

    for (int i = 0; i < NS; i++) prog_write(i, rand_ent());

    prog_write(0, mk_ent(0, 0, 4'h0, 13'h1FFF, 3));
    prog_write(1, mk_ent(0, 0, 4'hA, 13'h0000, 0));
    run_prog(1, 0, 0, -1, 0, "two_step");

    prog_write(0, mk_ent(1, 0, 4'h0, 13'h0000, 20));
    run_prog(0, 1, 0, -1, 0, "pump");

    vt[0] = '{1, 1, 0, 1, 1, 1};
    for (int i = 1; i < 8; i++) vt[i] = '{0, 0, 0, 1, 1, 1};
    vt[8]  = '{0, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 0};
    vt[10] = '{0, 1, 0, 1, 1, 1};
    vt[11] = '{1, 0, 0, 1, 1, 1};
    vt[12] = '{0, 0, 1, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      out_t e;
      bus.start = vt[i].st; bus.flush_req = vt[i].fl; bus.abort = vt[i].ab;
      tick();
      clear_inputs();
      e = vt[i].ones ? '1 : '0;
      e.busy = vt[i].busy; e.flush = vt[i].flush; e.done = 1'b0; e.idx = '0;
      check(e, "flush_vec", i);
    end

    for (int i = 0; i < 3; i++) prog_write(i, mk_ent(1, 1, 4'(i + 1), 13'(i + 7), 4));
    run_prog(2, 2, 0, 7, 0, "abort");
    run_prog(2, 2, 0, -1, 0, "after_abort");

    run_prog(0, 0, 1, -1, 2, "we_run");
    run_prog(0, 1, 0, -1, 0, "rerun");
    run_prog(1, 1, 0, -1, 1, "done_flush");

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 1) != 0) prog_write(i, rand_ent());
      run_prog($urandom_range(0, 3), $urandom_range(0, 3), 1, -1, 0, "rand");
    end

    prog_write(0, mk_ent(0, 0, 4'h0, 13'h1FFF, 10));
    bus.last_step = 4'd0; bus.pump_div = 12'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check({1'b1, 1'b0, 1'b0, 4'd0, 13'h1FFF, 4'h0, 3'b111, 2'b11}, "pre_rst", 0);
    tick();
    #2 rst_n = 1'b0;
    #1 check('0, "async_rst", 0);
    #3 rst_n = 1'b1;
    tick();
    check('0, "post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
